// File: rtl/cdc_fifo_pkg.sv
// Shared types and constants for the CDC FIFO read-side blocks.
// Used by cdc_fifo_read_port, which has the optional macro CDC_FIFO_READ_PORT_FLUSH_EN.
package cdc_fifo_pkg;

  localparam int DEFAULT_BUFFER_DEPTH = 2;
  localparam int READ_LATENCY = 1;

  typedef logic [$clog2(DEFAULT_BUFFER_DEPTH+1)-1:0] occupancy_t;

  typedef enum logic [1:0] {
    RP_EMPTY,
    RP_PARTIAL,
    RP_FULL
  } read_port_state_e;

  function automatic read_port_state_e occupancy_state(input int occupancy, input int depth);
    if (occupancy == 0) return RP_EMPTY;
    if (occupancy >= depth) return RP_FULL;
    return RP_PARTIAL;
  endfunction

endpackage

// File: rtl/cdc_fifo_prefetch_buffer.sv
// Small register-array FIFO that holds words returned by storage until the consumer takes them.
// The head entry is presented directly so the output is a plain register with no path from pop.
module cdc_fifo_prefetch_buffer #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 2,
  localparam int OCC_W     = $clog2(DEPTH + 1),
  localparam int PTR_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  clear,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] head_data,
  output logic [OCC_W-1:0]      occupancy
);

  logic [DATA_WIDTH-1:0] entries [DEPTH];
  logic [PTR_W-1:0]      head;
  logic [PTR_W-1:0]      tail;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] ptr);
    if (ptr == PTR_W'(DEPTH - 1)) return '0;
    return ptr + 1'b1;
  endfunction

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) entries[i] <= '0;
      head      <= '0;
      tail      <= '0;
      occupancy <= '0;
    end else if (clear) begin
      // Contents are left in place; only the bookkeeping is discarded.
      head      <= '0;
      tail      <= '0;
      occupancy <= '0;
    end else begin
      if (push) begin
        entries[tail] <= push_data;
        tail          <= next_ptr(tail);
      end
      if (pop) head <= next_ptr(head);
      occupancy <= occupancy + OCC_W'(push) - OCC_W'(pop);
    end
  end

  assign head_data = entries[head];

endmodule

// File: rtl/cdc_fifo_read_port.sv
// Read-side output stage of the CDC FIFO: issues storage reads and presents a registered valid/ready stream.
// Optional macro CDC_FIFO_READ_PORT_FLUSH_EN adds a synchronous flush input.
module cdc_fifo_read_port
  import cdc_fifo_pkg::*;
#(
  parameter int DATA_WIDTH   = 8,
  parameter int BUFFER_DEPTH = 2
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  empty,
  output logic                  increment,
  output logic                  mem_read_enable,
  input  logic [DATA_WIDTH-1:0] mem_read_data,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready
`ifdef CDC_FIFO_READ_PORT_FLUSH_EN
  ,
  input  logic                  flush
`endif
);

  localparam int OCC_W = $clog2(BUFFER_DEPTH + 1);

  generate
    if (BUFFER_DEPTH < 2) begin : g_depth_check
      $error("cdc_fifo_read_port: BUFFER_DEPTH must be at least 2");
    end
  endgenerate

  logic             inflight;
  logic             fetch;
  logic             pop;
  logic             flush_now;
  logic [OCC_W-1:0] occupancy;
  read_port_state_e state;

`ifdef CDC_FIFO_READ_PORT_FLUSH_EN
  assign flush_now = flush;
`else
  assign flush_now = 1'b0;
`endif

  assign pop   = out_valid & out_ready;
  // A full buffer may still fetch when a pop frees a slot at the same edge the new word is requested.
  assign fetch = !empty && !reset && !flush_now &&
                 (((int'(occupancy) + int'(inflight)) < BUFFER_DEPTH) || pop);

  assign increment       = fetch;
  assign mem_read_enable = fetch;

  always_ff @(posedge clock or posedge reset) begin
    if (reset)          inflight <= 1'b0;
    else if (flush_now) inflight <= 1'b0;
    else                inflight <= fetch;
  end

  cdc_fifo_prefetch_buffer #(
    .DATA_WIDTH(DATA_WIDTH),
    .DEPTH     (BUFFER_DEPTH)
  ) u_buffer (
    .clock    (clock),
    .reset    (reset),
    .clear    (flush_now),
    .push     (inflight),
    .push_data(mem_read_data),
    .pop      (pop),
    .head_data(out_data),
    .occupancy(occupancy)
  );

  assign out_valid = (occupancy != '0);
  assign state     = occupancy_state(int'(occupancy), BUFFER_DEPTH);

  a_no_overcommit: assert property (@(posedge clock) disable iff (reset)
    (int'(occupancy) + int'(inflight)) <= BUFFER_DEPTH);

  a_full_needs_pop: assert property (@(posedge clock) disable iff (reset)
    (state == RP_FULL && !pop) |-> !fetch);

endmodule

// File: doc/cdc_fifo_read_port.md
Name: cdc_fifo_read_port

Overview:
Read-side output stage of the CDC FIFO, directly downstream of the read-state block. Consumes that block's empty flag and drives its increment/pop. Issues reads to the synchronous-read storage array and presents the returned words as a registered valid/ready stream. A 2-entry prefetch buffer hides the 1-cycle memory read latency, so the port sustains one word per cycle with no combinational path from out_ready to out_data.

Parameters:
DATA_WIDTH, 8, width of one FIFO word.
BUFFER_DEPTH, 2, prefetch entries; fixed minimum 2, values below 2 are an elaboration error.

Ports:
clock  input  1  read-domain clock
reset  input  1  asynchronous, active-high reset
empty  input  1  from read-state block; 1 = no word available at current read address
increment  output  1  pop to read-state block; read address advances on the same edge
mem_read_enable  output  1  storage read strobe; always equal to increment
mem_read_data  input  DATA_WIDTH  storage output; valid the cycle after mem_read_enable
out_data  output  DATA_WIDTH  head-of-buffer word
out_valid  output  1  out_data holds a word
out_ready  input  1  consumer accepts out_data

Behaviour:
- Storage is sampled at the same edge on which the read address advances, so the pre-increment address is read. Read latency is exactly 1 cycle.
- State registers:
  - inflight: 1 bit; set on a fetch, cleared when the data returns.
  - occupancy: 0..BUFFER_DEPTH.
  - head/tail pointers into a register array.
- pop = out_valid & out_ready.
- fetch = !empty & !reset & ((occupancy + inflight < BUFFER_DEPTH) | pop).
- increment = mem_read_enable = fetch. Combinational, and 0 while reset is asserted.
- Next cycle after a fetch: inflight=1, and mem_read_data is written at the tail.
- Occupancy update: occupancy_next = occupancy + inflight - pop. The sum never exceeds BUFFER_DEPTH; an assertion checks this.
- Occupancy states:
  - EMPTY (0): out_valid=0.
  - PARTIAL: out_valid=1.
  - FULL (BUFFER_DEPTH): out_valid=1, fetch allowed only when pop=1.
- Transitions follow occupancy_next.
- Simultaneous arrival and pop: the buffer keeps its occupancy and the head advances.
- First-word latency: empty deasserts at cycle T → increment at T → out_valid at T+2.
- Steady state: occupancy=1, inflight=1, out_ready=1 gives one word per cycle.
- out_data is the head register and changes only on a pop or on arrival into an empty buffer. It holds stable while out_valid & !out_ready.
- Pointers wrap modulo BUFFER_DEPTH.
- empty rising with a fetch in flight: the in-flight word still lands. No more fetches are issued.
- Reset values (asynchronous): occupancy=0, inflight=0, pointers=0, out_valid=0, out_data=0, buffer contents=0, increment=0.
- Reset mid-operation: the in-flight word is discarded. The read-state block resets together with this block.

Optional Feature:
CDC_FIFO_READ_PORT_FLUSH_EN.
- Defined:
  - Adds input flush (1 bit).
  - A synchronous flush clears occupancy, inflight and pointers, and suppresses fetch in the flush cycle.
  - Returning data in the cycle after a flush is dropped.
  - out_valid=0 in the cycle after flush.
- Undefined: no flush port; behaviour as above.

Decomposition:
- Package cdc_fifo_pkg:
  - occupancy_t (logic [$clog2(BUFFER_DEPTH+1)-1:0] for the default depth).
  - Localparam READ_LATENCY=1.
  - Enum read_port_state_e {RP_EMPTY, RP_PARTIAL, RP_FULL}, used for debug/assertion visibility.
- One natural sub-module: cdc_fifo_prefetch_buffer. It is the register array with head/tail/occupancy and push/pop, instantiated once; the top handles fetch and inflight.

Test Plan:
- Reset, then release with empty=1 for 10 cycles → increment=0, out_valid=0, out_data=0 throughout.
- empty falls at cycle 5 with memory word 0xA5, out_ready=1 → increment=1 at cycle 5, out_valid=1 with out_data=0xA5 at cycle 7.
- 16 words 0x00..0x0F available, out_ready=1 continuously → out_valid held high, one word per cycle in order, increment high for 16 consecutive cycles.
- Same 16 words, out_ready=0 for 6 cycles → exactly 2 increments, then occupancy=2 and increment=0. out_data stays 0x00. On resuming out_ready, output is 0x00,0x01,0x02… with no loss or duplication.
- Random out_ready toggling with empty toggling over 1000 words → scoreboard matches in order, occupancy+inflight ≤ 2 always.
- Reset pulse while occupancy=2 and inflight=1 → out_valid=0 and increment=0 immediately. After reset, the first word delivered is the first word written after reset.
- (Flush build only) flush with occupancy=2 → out_valid=0 next cycle, the stale in-flight word is not presented.
